// File: rtl/branch_resolve_if.sv
// Decode/fetch-side signal bundle for branch_resolve: flag inputs, branch
// requests and fetch back-pressure in, fetch address and branch status out.
interface branch_resolve_if #(
    parameter int unsigned PC_W = 8
);
    logic [3:0]      flags;
    logic            flag_wr_pending;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            stall;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            br_taken;
    logic            busy;

    modport master (
        output flags, flag_wr_pending, br_valid, br_cond, br_target, stall,
        input  pc, fetch_valid, br_taken, busy
    );

    modport slave (
        input  flags, flag_wr_pending, br_valid, br_cond, br_target, stall,
        output pc, fetch_valid, br_taken, busy
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution and PC sequencing: evaluates branch conditions against the
// ALU flags, waits one cycle on a pending flag write, and flushes fetch after a taken branch.
module branch_resolve #(
    parameter int unsigned PC_W         = 8,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            br_taken_q, br_taken_d;
    logic            busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      cond_q, cond_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [PC_W-1:0] pc_inc;
    logic            cond_is_static;

    // Flag bits: [3]=Z, [2]=V, [1]=C, [0]=N
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic met;
        case (cond)
            3'b000:  met = 1'b1;
            3'b001:  met = f[3];
            3'b010:  met = ~f[3];
            3'b011:  met = f[1];
            3'b100:  met = ~f[1];
            3'b101:  met = f[0];
            3'b110:  met = f[2];
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    assign pc_inc         = pc_q + PC_W'(1);
    assign cond_is_static = (bus.br_cond == 3'b000) || (bus.br_cond == 3'b111);

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        br_taken_d    = 1'b0;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        cond_d        = cond_q;
        target_d      = target_q;

        case (state_q)
            ST_RUN: begin
                if (bus.br_valid) begin
                    cond_d   = bus.br_cond;
                    target_d = bus.br_target;
                    if (bus.flag_wr_pending && !cond_is_static) begin
                        state_d       = ST_HOLD;
                        fetch_valid_d = 1'b0;
                        busy_d        = 1'b1;
                    end else if (cond_met(bus.br_cond, bus.flags)) begin
                        state_d       = ST_FLUSH;
                        pc_d          = bus.br_target;
                        br_taken_d    = 1'b1;
                        fetch_valid_d = 1'b0;
                        busy_d        = 1'b1;
                        cnt_d         = CNT_W'(FLUSH_CYCLES);
                    end else begin
                        pc_d          = pc_inc;
                        fetch_valid_d = 1'b1;
                    end
                end else begin
                    // pc only advances once the current address has actually been fetched
                    fetch_valid_d = 1'b1;
                    if (fetch_valid_q && !bus.stall) begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (cond_met(cond_q, bus.flags)) begin
                    state_d       = ST_FLUSH;
                    pc_d          = target_q;
                    br_taken_d    = 1'b1;
                    fetch_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    cnt_d         = CNT_W'(FLUSH_CYCLES);
                end else begin
                    state_d       = ST_RUN;
                    pc_d          = pc_inc;
                    fetch_valid_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d       = ST_RUN;
                    cnt_d         = '0;
                    fetch_valid_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            br_taken_q    <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            cond_q        <= '0;
            target_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            br_taken_q    <= br_taken_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            cond_q        <= cond_d;
            target_q      <= target_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.br_taken    = br_taken_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: two instances (flush length 1 and 3) share
// one stimulus stream; a cycle-level reference model predicts each instance's outputs.
module tb_branch_resolve;
    typedef struct packed {
        logic [7:0] pc;
        logic       fv;
        logic       tk;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst;
    logic [3:0] in_flags;
    logic       in_wrp;
    logic       in_bv;
    logic [2:0] in_cond;
    logic [7:0] in_tgt;
    logic       in_stall;

    int n_checks;
    int n_fail;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, index 0 = flush 1, index 1 = flush 3
    logic [7:0] m_pc[2];
    logic       m_fv[2];
    logic       m_busy[2];
    logic       m_hold[2];
    logic [2:0] m_cond[2];
    logic [7:0] m_tgt[2];
    int         m_flush[2];

    branch_resolve_if #(.PC_W(8)) if1 ();
    branch_resolve_if #(.PC_W(8)) if3 ();

    assign if1.flags = in_flags;  assign if3.flags = in_flags;
    assign if1.flag_wr_pending = in_wrp;  assign if3.flag_wr_pending = in_wrp;
    assign if1.br_valid = in_bv;  assign if3.br_valid = in_bv;
    assign if1.br_cond = in_cond;  assign if3.br_cond = in_cond;
    assign if1.br_target = in_tgt;  assign if3.br_target = in_tgt;
    assign if1.stall = in_stall;  assign if3.stall = in_stall;

    branch_resolve #(.PC_W(8), .FLUSH_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));
    branch_resolve #(.PC_W(8), .FLUSH_CYCLES(3)) dut3 (.clk(clk), .reset(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
        logic z, v, cy, n;
        z = f[3]; v = f[2]; cy = f[1]; n = f[0];
        if (c == 3'd0) return 1'b1;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z;
        if (c == 3'd3) return cy;
        if (c == 3'd4) return !cy;
        if (c == 3'd5) return n;
        if (c == 3'd6) return v;
        return 1'b0;
    endfunction

    // Predict outputs after the coming edge from the inputs now applied
    task automatic model_step(input int k, input int flush_len);
        exp_t e;
        logic taken;
        logic [7:0] dest;
        taken = 1'b0;
        dest  = 8'h00;
        if (rst) begin
            m_pc[k] = 8'h00; m_fv[k] = 1'b0; m_busy[k] = 1'b0;
            m_hold[k] = 1'b0; m_flush[k] = 0; m_cond[k] = 3'd0; m_tgt[k] = 8'h00;
        end else if (m_hold[k]) begin
            m_hold[k] = 1'b0;
            if (cond_true(m_cond[k], in_flags)) begin
                taken = 1'b1; dest = m_tgt[k];
            end else begin
                m_pc[k] = m_pc[k] + 8'd1; m_fv[k] = 1'b1; m_busy[k] = 1'b0;
            end
        end else if (m_flush[k] > 0) begin
            m_flush[k] = m_flush[k] - 1;
            if (m_flush[k] == 0) begin
                m_fv[k] = 1'b1; m_busy[k] = 1'b0;
            end
        end else if (in_bv) begin
            if (in_wrp && in_cond != 3'd0 && in_cond != 3'd7) begin
                m_hold[k] = 1'b1; m_cond[k] = in_cond; m_tgt[k] = in_tgt;
                m_fv[k] = 1'b0; m_busy[k] = 1'b1;
            end else if (cond_true(in_cond, in_flags)) begin
                taken = 1'b1; dest = in_tgt;
            end else begin
                m_pc[k] = m_pc[k] + 8'd1; m_fv[k] = 1'b1;
            end
        end else begin
            if (m_fv[k] && !in_stall) m_pc[k] = m_pc[k] + 8'd1;
            m_fv[k] = 1'b1;
        end
        if (taken) begin
            m_pc[k] = dest; m_fv[k] = 1'b0; m_busy[k] = 1'b1; m_flush[k] = flush_len;
        end
        e.pc = m_pc[k]; e.fv = m_fv[k]; e.tk = taken; e.busy = m_busy[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] f, input logic w, input logic bv,
                         input logic [2:0] c, input logic [7:0] t, input logic s);
        @(negedge clk);
        rst = r; in_flags = f; in_wrp = w; in_bv = bv; in_cond = c; in_tgt = t; in_stall = s;
        model_step(0, 1);
        model_step(1, 3);
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00, s);
    endtask

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (flush=%0d) t=%0t: got %0h, expected %0h", name, (k == 0) ? 1 : 3, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, pop one expectation per DUT per edge
    logic prev_tk[2];
    initial begin
        exp_t e;
        prev_tk[0] = 1'b0; prev_tk[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("pc", 0, if1.pc, e.pc);
                check("fetch_valid", 0, 8'(if1.fetch_valid), 8'(e.fv));
                check("br_taken", 0, 8'(if1.br_taken), 8'(e.tk));
                check("busy", 0, 8'(if1.busy), 8'(e.busy));
                check("br_taken_single_pulse", 0, 8'(prev_tk[0] & if1.br_taken), 8'h00);
                prev_tk[0] = if1.br_taken;
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("pc", 1, if3.pc, e.pc);
                check("fetch_valid", 1, 8'(if3.fetch_valid), 8'(e.fv));
                check("br_taken", 1, 8'(if3.br_taken), 8'(e.tk));
                check("busy", 1, 8'(if3.busy), 8'(e.busy));
                check("br_taken_single_pulse", 1, 8'(prev_tk[1] & if3.br_taken), 8'h00);
                prev_tk[1] = if3.br_taken;
            end
        end
    end

    initial begin
        int budget;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; in_flags = 4'h0; in_wrp = 1'b0; in_bv = 1'b0;
        in_cond = 3'd0; in_tgt = 8'h00; in_stall = 1'b0;

        // Reset, sequential fetch, reset again mid-stream
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(5, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(1, 1'b0);
        // Z-conditional taken branch, no hazard
        drive(1'b0, 4'b1000, 1'b0, 1'b1, 3'b001, 8'h40, 1'b0);
        idle(4, 1'b0);
        // Hazard: flags rewritten to 0000 at the same edge, branch falls through
        drive(1'b0, 4'b1000, 1'b1, 1'b1, 3'b001, 8'h99, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(2, 1'b0);
        // PC wrap and stall hold
        drive(1'b0, 4'h0, 1'b0, 1'b1, 3'b000, 8'hFE, 1'b0);
        idle(4, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        idle(1, 1'b0);
        // Request during FLUSH is ignored
        drive(1'b0, 4'h0, 1'b0, 1'b1, 3'b000, 8'h10, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 3'b000, 8'h80, 1'b0);
        idle(4, 1'b0);
        // Never-taken with all flags set, then carry-taken
        drive(1'b0, 4'b1111, 1'b0, 1'b1, 3'b111, 8'h55, 1'b0);
        drive(1'b0, 4'b0010, 1'b0, 1'b1, 3'b011, 8'h20, 1'b1);
        idle(5, 1'b0);
        // Hazard resolving taken
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 3'b101, 8'h33, 1'b0);
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(5, 1'b0);

        // Randomized traffic, including requests while busy and resets mid-branch
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0));
        end
        idle(2, 1'b0);

        budget = 0;
        while ((q0.size() > 0 || q1.size() > 0) && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
